// File: rtl/branch_cmp_pipe.sv
// Registered branch-condition unit: evaluates a MIPS branch condition on a/b and
// presents the taken decision one cycle later, with saturating branch statistics.
module branch_cmp_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             clr_cnt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    output logic             br,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam logic [3:0] OP_NEVER  = 4'b0000;
    localparam logic [3:0] OP_NE     = 4'b0001;
    localparam logic [3:0] OP_LEZ    = 4'b0010;
    localparam logic [3:0] OP_GTZ    = 4'b0011;
    localparam logic [3:0] OP_LTZ    = 4'b0100;
    localparam logic [3:0] OP_GEZ    = 4'b0101;
    localparam logic [3:0] OP_EQ     = 4'b0110;
    localparam logic [3:0] OP_ALWAYS = 4'b0111;
    localparam logic [3:0] OP_LT     = 4'b1000;
    localparam logic [3:0] OP_LTU    = 4'b1001;
    localparam logic [3:0] OP_GE     = 4'b1010;
    localparam logic [3:0] OP_GEU    = 4'b1011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic a_neg_c;
    logic a_zero_c;
    logic eq_c;
    logic lt_s_c;
    logic lt_u_c;
    logic cond_c;
    logic counted_c;
    logic accept_c;

    assign a_neg_c  = a[WIDTH-1];
    assign a_zero_c = (a == '0);
    assign eq_c     = (a == b);
    assign lt_s_c   = ($signed(a) < $signed(b));
    assign lt_u_c   = (a < b);
    assign accept_c = in_valid & ~stall & ~flush;

    // Condition decode; NEVER and unassigned codes are neither taken nor counted
    always_comb begin
        cond_c    = 1'b0;
        counted_c = 1'b1;
        case (op)
            OP_EQ:     cond_c = eq_c;
            OP_NE:     cond_c = ~eq_c;
            OP_LEZ:    cond_c = a_neg_c | a_zero_c;
            OP_GTZ:    cond_c = ~a_neg_c & ~a_zero_c;
            OP_LTZ:    cond_c = a_neg_c;
            OP_GEZ:    cond_c = ~a_neg_c;
            OP_LT:     cond_c = lt_s_c;
            OP_LTU:    cond_c = lt_u_c;
            OP_GE:     cond_c = ~lt_s_c;
            OP_GEU:    cond_c = ~lt_u_c;
            OP_ALWAYS: cond_c = 1'b1;
            OP_NEVER:  counted_c = 1'b0;
            default:   counted_c = 1'b0;
        endcase
    end

    // Output stage: flush beats stall; stall holds the previous result
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            br        <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            br        <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            br        <= in_valid & cond_c;
        end
    end

    // Statistics counters saturate independently; clear wins over increment
    always_ff @(posedge clk) begin
        if (reset || clr_cnt) begin
            cnt_total <= '0;
            cnt_taken <= '0;
        end else if (accept_c && counted_c) begin
            if (cnt_total != CNT_MAX) begin
                cnt_total <= cnt_total + CNT_W'(1);
            end
            if (cond_c && (cnt_taken != CNT_MAX)) begin
                cnt_taken <= cnt_taken + CNT_W'(1);
            end
        end
    end

endmodule
